// File: rtl/pepe8_pc_pkg.sv
// Shared definitions for the PEPE-8 program counter: SEL_PC opcodes, state encoding and
// default address width.
package pepe8_pc_pkg;

    localparam int unsigned ADDR_W_PADRAO = 8;

    localparam logic [2:0] OP_INC       = 3'b000;
    localparam logic [2:0] OP_JMP       = 3'b001;
    localparam logic [2:0] OP_JMP_SE    = 3'b010;
    localparam logic [2:0] OP_JMP_SENAO = 3'b011;
    localparam logic [2:0] OP_CALL      = 3'b100;
    localparam logic [2:0] OP_RET       = 3'b101;
    localparam logic [2:0] OP_HALT      = 3'b110;
    localparam logic [2:0] OP_NOP       = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERRO = 2'd2
    } estado_t;

endpackage

// File: rtl/pilha_retorno.sv
// Return-address LIFO: push/pop with full/empty flags and a read port on the top entry.
// Overflow/underflow policy is left to the parent.
module pilha_retorno #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned SW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [SW-1:0] sp_q, sp_d;
    logic [SW-1:0] sp_menos_1;

    assign full       = (sp_q == SW'(DEPTH));
    assign empty      = (sp_q == '0);
    assign sp_menos_1 = sp_q - SW'(1);
    assign dout       = empty ? '0 : mem[IW'(sp_menos_1)];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_menos_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Contents need no reset: only entries below SP are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IW'(sp_q)] <= din;
        end
    end

endmodule

// File: rtl/contador_de_programa.sv
// PEPE-8 program counter / next-address unit with call/return stack and halt/resume.
// Optional jump counter output N_SALTOS enabled by defining PC_CONTA_SALTOS_EN.
module contador_de_programa
    import pepe8_pc_pkg::*;
#(
    parameter int unsigned          ADDR_W      = ADDR_W_PADRAO,
    parameter logic [ADDR_W-1:0]    RESET_ADDR  = '0,
    parameter int unsigned          STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EN,
    input  logic [2:0]        SEL_PC,
    input  logic              S_FLAG,
    input  logic [ADDR_W-1:0] CONST,
    input  logic              RETOMAR,
    output logic [ADDR_W-1:0] PC,
    output logic              SALTO,
    output logic              HALTED,
    output logic              ERRO_PILHA
`ifdef PC_CONTA_SALTOS_EN
    ,
    output logic [7:0]        N_SALTOS
`endif
);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              salto_q, salto_d;
    logic              push, pop;
    logic [ADDR_W-1:0] topo;
    logic              cheia, vazia;

    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    pilha_retorno #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_pilha (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (topo),
        .full  (cheia),
        .empty (vazia)
    );

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        salto_d  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (EN) begin
            unique case (estado_q)
                ST_RUN: begin
                    unique case (SEL_PC)
                        OP_INC: pc_d = pc_inc;
                        OP_JMP: begin
                            pc_d    = CONST;
                            salto_d = 1'b1;
                        end
                        OP_JMP_SE, OP_JMP_SENAO: begin
                            // SEL_PC[0] selects which flag polarity takes the jump
                            if (S_FLAG != SEL_PC[0]) begin
                                pc_d    = CONST;
                                salto_d = 1'b1;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                        OP_CALL: begin
                            if (cheia) begin
                                estado_d = ST_ERRO;
                            end else begin
                                push    = 1'b1;
                                pc_d    = CONST;
                                salto_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (vazia) begin
                                estado_d = ST_ERRO;
                            end else begin
                                pop     = 1'b1;
                                pc_d    = topo;
                                salto_d = 1'b1;
                            end
                        end
                        OP_HALT: estado_d = ST_HALT;
                        default: ;
                    endcase
                end
                ST_HALT: begin
                    if (RETOMAR) begin
                        estado_d = ST_RUN;
                        pc_d     = pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ST_RUN;
            pc_q     <= RESET_ADDR;
            salto_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            salto_q  <= salto_d;
        end
    end

    assign PC         = pc_q;
    assign SALTO      = salto_q;
    assign HALTED     = (estado_q == ST_HALT);
    assign ERRO_PILHA = (estado_q == ST_ERRO);

`ifdef PC_CONTA_SALTOS_EN
    logic [7:0] n_saltos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_saltos_q <= '0;
        end else if (salto_d && (n_saltos_q != 8'hFF)) begin
            n_saltos_q <= n_saltos_q + 8'd1;
        end
    end

    assign N_SALTOS = n_saltos_q;
`endif

endmodule

// File: tb/tb_contador_de_programa.sv
// Directed self-checking bench for contador_de_programa; exercises N_SALTOS when
// PC_CONTA_SALTOS_EN is defined.
module tb_contador_de_programa;

    localparam logic [2:0] INC = 3'b000, JMP = 3'b001, JSE = 3'b010, JSN = 3'b011;
    localparam logic [2:0] CALL = 3'b100, RET = 3'b101, HALT = 3'b110, NOP = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [2:0] sel = NOP;
    logic       flag = 1'b0;
    logic [7:0] cst = 8'h00;
    logic       retomar = 1'b0;
    logic [7:0] pc;
    logic       salto, halted, erro;
`ifdef PC_CONTA_SALTOS_EN
    logic [7:0] n_saltos;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    contador_de_programa #(
        .ADDR_W      (8),
        .RESET_ADDR  (8'h00),
        .STACK_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .EN         (en),
        .SEL_PC     (sel),
        .S_FLAG     (flag),
        .CONST      (cst),
        .RETOMAR    (retomar),
        .PC         (pc),
        .SALTO      (salto),
        .HALTED     (halted),
        .ERRO_PILHA (erro)
`ifdef PC_CONTA_SALTOS_EN
        ,
        .N_SALTOS   (n_saltos)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one operation and advance to just after the next rising edge.
    task automatic ciclo(input logic [2:0] s, input logic [7:0] c, input logic f = 1'b0,
                         input logic e = 1'b1, input logic r = 1'b0);
        sel     = s;
        cst     = c;
        flag    = f;
        en      = e;
        retomar = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [7:0] exp_pc, input logic exp_salto);
        check_eq({tag, ".pc"}, {24'd0, pc}, {24'd0, exp_pc});
        check_eq({tag, ".salto"}, {31'd0, salto}, {31'd0, exp_salto});
    endtask

    task automatic sai_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        #2;
        check_pc("reset", 8'h00, 1'b0);
        check_eq("reset.halted", {31'd0, halted}, 32'd0);
        check_eq("reset.erro", {31'd0, erro}, 32'd0);
        sai_reset();

        ciclo(INC, 8'h00); check_pc("inc1", 8'h01, 1'b0);
        ciclo(INC, 8'h00); check_pc("inc2", 8'h02, 1'b0);
        ciclo(INC, 8'h00); check_pc("inc3", 8'h03, 1'b0);

        ciclo(JMP, 8'h10);       check_pc("jmp10", 8'h10, 1'b1);
        ciclo(JSE, 8'h40, 1'b0); check_pc("jse_f0", 8'h11, 1'b0);
        ciclo(JSN, 8'h40, 1'b0); check_pc("jsn_f0", 8'h40, 1'b1);
        ciclo(NOP, 8'h00);       check_pc("nop", 8'h40, 1'b0);
        ciclo(JSE, 8'h70, 1'b1); check_pc("jse_f1", 8'h70, 1'b1);
        ciclo(JSN, 8'h20, 1'b1); check_pc("jsn_f1", 8'h71, 1'b0);

        ciclo(JMP, 8'hFF); check_pc("jmpff", 8'hFF, 1'b1);
        ciclo(INC, 8'h00); check_pc("wrap", 8'h00, 1'b0);
        check_eq("wrap.erro", {31'd0, erro}, 32'd0);

        ciclo(JMP, 8'h05);              check_pc("jmp05", 8'h05, 1'b1);
        ciclo(JMP, 8'h77, 1'b0, 1'b0);  check_pc("en0", 8'h05, 1'b0);

        // Nested call/return
        ciclo(CALL, 8'h20); check_pc("call20", 8'h20, 1'b1);
        ciclo(CALL, 8'h30); check_pc("call30", 8'h30, 1'b1);
        ciclo(RET, 8'h00);  check_pc("ret1", 8'h21, 1'b1);
        ciclo(RET, 8'h00);  check_pc("ret2", 8'h06, 1'b1);

        // Overflow: four pushes fill the stack, the fifth errors out
        ciclo(CALL, 8'h10);
        ciclo(CALL, 8'h11);
        ciclo(CALL, 8'h12);
        ciclo(CALL, 8'h13); check_pc("call4", 8'h13, 1'b1);
        check_eq("call4.erro", {31'd0, erro}, 32'd0);
        ciclo(CALL, 8'h50); check_pc("ovf", 8'h13, 1'b0);
        check_eq("ovf.erro", {31'd0, erro}, 32'd1);
        ciclo(JMP, 8'h00);
        ciclo(INC, 8'h00);  check_pc("erro_hold", 8'h13, 1'b0);
        check_eq("erro_hold.erro", {31'd0, erro}, 32'd1);

        // Asynchronous reset in the middle of a call sequence
        #2 rst_n = 1'b0;
        #1;
        check_pc("async_rst", 8'h00, 1'b0);
        check_eq("async_rst.erro", {31'd0, erro}, 32'd0);
        sai_reset();
        ciclo(CALL, 8'h20);
        ciclo(CALL, 8'h30); check_pc("mid_call", 8'h30, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_pc("mid_rst", 8'h00, 1'b0);
        sai_reset();
        // Empty stack after reset: RET must fail
        ciclo(RET, 8'h00); check_pc("udf", 8'h00, 1'b0);
        check_eq("udf.erro", {31'd0, erro}, 32'd1);

        #2 rst_n = 1'b0;
        sai_reset();
        check_eq("rst2.erro", {31'd0, erro}, 32'd0);

        // Halt and resume
        ciclo(JMP, 8'h08);
        ciclo(HALT, 8'h00); check_pc("halt", 8'h08, 1'b0);
        check_eq("halt.halted", {31'd0, halted}, 32'd1);
        ciclo(JMP, 8'h60);
        ciclo(JMP, 8'h61);  check_pc("halt_hold", 8'h08, 1'b0);
        check_eq("halt_hold.halted", {31'd0, halted}, 32'd1);
        ciclo(JMP, 8'h60, 1'b0, 1'b0, 1'b1); check_pc("ret_en0", 8'h08, 1'b0);
        check_eq("ret_en0.halted", {31'd0, halted}, 32'd1);
        ciclo(JMP, 8'h60, 1'b0, 1'b1, 1'b1); check_pc("retomar", 8'h09, 1'b0);
        check_eq("retomar.halted", {31'd0, halted}, 32'd0);
        ciclo(INC, 8'h00); check_pc("pos_halt", 8'h0A, 1'b0);

`ifdef PC_CONTA_SALTOS_EN
        #2 rst_n = 1'b0;
        #1;
        check_eq("nsaltos.rst", {24'd0, n_saltos}, 32'd0);
        sai_reset();
        for (int i = 0; i < 10; i++) ciclo(JMP, 8'h33);
        check_eq("nsaltos.10", {24'd0, n_saltos}, 32'd10);
        ciclo(JMP, 8'h33, 1'b0, 1'b0);
        check_eq("nsaltos.en0", {24'd0, n_saltos}, 32'd10);
        for (int i = 0; i < 290; i++) ciclo(JMP, 8'h33);
        check_eq("nsaltos.sat", {24'd0, n_saltos}, 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_de_programa.md
Name: contador_de_programa

Overview:
- Program counter and next-address unit of the PEPE-8 core; directly downstream of the flags register.
- Consumes the flag register's selected-condition output S_FLAG in the same cycle and produces the instruction-memory fetch address.
- Supports sequential increment, absolute and conditional jumps, call/return through an internal return-address stack, and halt/resume.

Parameters:
- ADDR_W, 8, width of the program address and of PC.
- RESET_ADDR, 0, PC value after reset.
- STACK_DEPTH, 4, number of return-address stack entries (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EN  in  1  advance enable; 0 freezes all state.
- SEL_PC  in  3  next-address operation, decoded by the control unit:
  - 000 INC
  - 001 JMP
  - 010 JMP_SE (jump if S_FLAG=1)
  - 011 JMP_SENAO (jump if S_FLAG=0)
  - 100 CALL
  - 101 RET
  - 110 HALT
  - 111 NOP
- S_FLAG  in  1  selected flag from the flags register, sampled combinationally in the same cycle as SEL_PC.
- CONST  in  ADDR_W  jump/call target from the instruction word.
- RETOMAR  in  1  resume request while halted.
- PC  out  ADDR_W  current fetch address (registered).
- SALTO  out  1  registered 1-cycle pulse: PC was loaded non-sequentially on the last edge.
- HALTED  out  1  state is HALT.
- ERRO_PILHA  out  1  state is ERRO (stack overflow or underflow).

Behaviour:
- Reset, asynchronous with rst_n=0:
  - PC=RESET_ADDR, state RUN, stack pointer SP=0.
  - SALTO=0, HALTED=0, ERRO_PILHA=0.
  - Stack contents are don't-care.
- States: RUN, HALT, ERRO. All updates occur on the rising clk edge, only when EN=1.
- EN=0: PC, SP, state and stack held; SALTO=0 on that edge.
- RUN, EN=1 (PC+1 is modulo 2^ADDR_W, so 0xFF→0x00 with no flag):
  - INC: PC<=PC+1.
  - JMP: PC<=CONST; SALTO<=1.
  - JMP_SE: if S_FLAG=1, PC<=CONST and SALTO<=1; otherwise PC<=PC+1.
  - JMP_SENAO: mirror of JMP_SE on S_FLAG=0.
  - CALL, SP<STACK_DEPTH: push PC+1 at stack[SP]; SP<=SP+1; PC<=CONST; SALTO<=1.
  - CALL, SP==STACK_DEPTH (full): state<=ERRO; PC and SP held; no write.
  - RET, SP>0: PC<=stack[SP-1]; SP<=SP-1; SALTO<=1.
  - RET, SP==0 (empty): state<=ERRO; PC held.
  - HALT: state<=HALT; PC held.
  - NOP: all held.
- HALT: SEL_PC ignored. RETOMAR=1 with EN=1 → state<=RUN and PC<=PC+1 (resumes after the HALT instruction); SALTO stays 0.
- ERRO: terminal; everything held until rst_n asserts.
- HALTED and ERRO_PILHA decode the registered state, so they are valid the cycle after entry.
- Latency: one cycle from SEL_PC/CONST/S_FLAG to the new PC.
- Reset asserted mid-operation overrides everything immediately.
- SP width: $clog2(STACK_DEPTH+1).

Optional Feature:
- Macro PC_CONTA_SALTOS_EN.
- Defined:
  - Extra output N_SALTOS (8 bits) counts edges on which SALTO is set.
  - Saturates at 255; reset to 0.
  - Held when EN=0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package pepe8_pc_pkg:
  - SEL_PC opcode localparams (OP_INC … OP_NOP).
  - State encoding (ST_RUN=2'd0, ST_HALT=2'd1, ST_ERRO=2'd2).
  - Default ADDR_W.
- Sub-module pilha_retorno:
  - Parameterised LIFO (DEPTH, W) with push/pop, full/empty flags and read port stack[SP-1].
  - Overflow/underflow detection stays in the parent.

Test Plan:
- Reset then 3 cycles INC, EN=1 → PC 0x00,0x01,0x02,0x03; SALTO=0 throughout.
- PC=0x10, JMP_SE, CONST=0x40:
  - S_FLAG=0 → PC=0x11, SALTO=0.
  - Next cycle, JMP_SENAO with S_FLAG=0 → PC=0x40, SALTO=1 for one cycle.
- PC=0xFF, INC → PC=0x00, no error; PC=0x05, EN=0 with JMP → PC stays 0x05.
- Nested calls, STACK_DEPTH=4:
  - CALL 0x20 from PC=0x05, then CALL 0x30 → PC=0x30, SP=2.
  - RET → PC=0x21; RET → PC=0x06.
  - A fifth CALL with stack full → ERRO_PILHA=1, PC frozen until reset.
- RET right after reset → ERRO_PILHA=1, PC=0x00.
- HALT at PC=0x08 → HALTED=1, PC=0x08 held across JMP inputs; RETOMAR=1 → HALTED=0, PC=0x09.
- Reset asserted mid-CALL sequence → PC=0x00, SP=0 asynchronously.
- With PC_CONTA_SALTOS_EN: 300 consecutive JMPs → N_SALTOS=255.
